// File: rtl/codec_sample_bridge.sv
// Sample bridge between the synth core and the codec: buffers core samples in a
// small FIFO and releases one attenuated sample per codec frame strobe.
module codec_sample_bridge #(
  parameter int DEPTH  = 8,
  parameter int PRIME  = 2,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     new_frame,
  input  logic [2:0]               volume,
  output logic signed [DATA_W-1:0] codec_sample,
  output logic                     codec_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               underrun_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  function automatic logic signed [DATA_W-1:0] attenuate(
    input logic signed [DATA_W-1:0] s,
    input logic [2:0]               sh
  );
    return s >>> sh;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]          level_q, level_d;
  logic                      overflow_q, overflow_d;
  logic [7:0]                underrun_q, underrun_d;
  logic signed [DATA_W-1:0]  codec_sample_q, codec_sample_d;
  logic                      codec_valid_q, codec_valid_d;
  logic signed [DATA_W-1:0]  mem_q [DEPTH];

  logic full;
  logic empty;
  logic pop_en;
  logic push_en;

  always_comb begin
    full    = (level_q == LVL_W'(DEPTH));
    empty   = (level_q == '0);
    pop_en  = new_frame && (state_q == RUN) && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    push_en = sample_valid && (!full || pop_en);

    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
    overflow_d     = overflow_q | (sample_valid & ~push_en);
    underrun_d     = underrun_q;
    codec_sample_d = codec_sample_q;
    codec_valid_d  = new_frame;

    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (new_frame) begin
      codec_sample_d = pop_en ? attenuate(mem_q[rd_ptr_q], volume) : '0;
    end

    // Priming looks at the registered level, so a frame in the cycle the level
    // first reaches PRIME is still served as silence.
    case (state_q)
      FILL: begin
        if (level_q >= LVL_W'(PRIME)) state_d = RUN;
      end
      RUN: begin
        if (new_frame && empty) begin
          state_d    = FILL;
          underrun_d = sat_inc(underrun_q);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      underrun_q     <= 8'd0;
      codec_sample_q <= '0;
      codec_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      underrun_q     <= underrun_d;
      codec_sample_q <= codec_sample_d;
      codec_valid_q  <= codec_valid_d;
    end
  end

  // Storage is data only; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= sample_in;
  end

  assign codec_sample   = codec_sample_q;
  assign codec_valid    = codec_valid_q;
  assign fifo_level     = level_q;
  assign overflow       = overflow_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_codec_sample_bridge.sv
// Directed bench for codec_sample_bridge: a vector table for the basic flow
// plus hand-written sequences for overflow, saturation and mid-stream reset.
module tb_codec_sample_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_in = 16'h0;
  logic        sample_valid = 1'b0;
  logic        new_frame = 1'b0;
  logic [2:0]  volume = 3'd0;
  logic [15:0] codec_sample;
  logic        codec_valid;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  underrun_count;

  int checks = 0;
  int errors = 0;

  codec_sample_bridge #(.DEPTH(8), .PRIME(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .new_frame      (new_frame),
    .volume         (volume),
    .codec_sample   (codec_sample),
    .codec_valid    (codec_valid),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [15:0] din;
    logic        nf;
    logic [2:0]  vol;
    logic [15:0] e_smp;
    logic        e_vld;
    logic [3:0]  e_lvl;
    logic        e_ovf;
    logic [7:0]  e_unr;
  } vec_t;

  vec_t vt [24];

  task automatic step(input logic r, input logic sv, input logic [15:0] d,
                      input logic nf, input logic [2:0] v);
    reset        = r;
    sample_valid = sv;
    sample_in    = d;
    new_frame    = nf;
    volume       = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] smp, input logic vld,
                         input logic [3:0] lvl, input logic ovf, input logic [7:0] unr);
    chk({tag, " sample"}, 32'(codec_sample), 32'(smp));
    chk({tag, " valid"}, 32'(codec_valid), 32'(vld));
    chk({tag, " level"}, 32'(fifo_level), 32'(lvl));
    chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, " underrun"}, 32'(underrun_count), 32'(unr));
  endtask

  initial begin
    logic [15:0] r [8];
    int exp_unr;

    //        rst   sv    din       nf    vol     smp       vld   lvl   ovf   unr
    vt[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0};
    vt[1]  = '{1'b0, 1'b1, 16'h1000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd1, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd1, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 1'b1, 16'h2000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd2, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd2, 1'b0, 8'd0};
    vt[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h1000, 1'b1, 4'd1, 1'b0, 8'd0};
    vt[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h1000, 1'b0, 4'd1, 1'b0, 8'd0};
    vt[7]  = '{1'b0, 1'b1, 16'h7FFE, 1'b0, 3'd0, 16'h1000, 1'b0, 4'd2, 1'b0, 8'd0};
    vt[8]  = '{1'b0, 1'b1, 16'h8000, 1'b0, 3'd0, 16'h1000, 1'b0, 4'd3, 1'b0, 8'd0};
    vt[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h2000, 1'b1, 4'd2, 1'b0, 8'd0};
    vt[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 16'h1FFF, 1'b1, 4'd1, 1'b0, 8'd0};
    vt[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 16'hE000, 1'b1, 4'd0, 1'b0, 8'd0};
    vt[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 8'd1};
    vt[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 8'd1};
    vt[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd0, 1'b0, 8'd1};
    vt[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 8'd1};
    vt[16] = '{1'b0, 1'b1, 16'h0100, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd1, 1'b0, 8'd1};
    vt[17] = '{1'b0, 1'b1, 16'h0200, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd2, 1'b0, 8'd1};
    vt[18] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd2, 1'b0, 8'd1};
    vt[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h0080, 1'b1, 4'd1, 1'b0, 8'd1};
    vt[20] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h0100, 1'b1, 4'd0, 1'b0, 8'd1};
    vt[21] = '{1'b0, 1'b1, 16'h0300, 1'b1, 3'd1, 16'h0000, 1'b1, 4'd1, 1'b0, 8'd2};
    vt[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 4'd1, 1'b0, 8'd2};
    vt[23] = '{1'b0, 1'b0, 16'h0000, 1'b1, 3'd0, 16'h0000, 1'b1, 4'd1, 1'b0, 8'd2};

    for (int i = 0; i < 24; i++) begin
      step(vt[i].rst, vt[i].sv, vt[i].din, vt[i].nf, vt[i].vol);
      chk_all($sformatf("vec%0d", i), vt[i].e_smp, vt[i].e_vld, vt[i].e_lvl,
              vt[i].e_ovf, vt[i].e_unr);
    end

    // Overflow: nine pushes into an eight-entry FIFO, then drain in order.
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    chk_all("ovf reset", 16'h0, 1'b0, 4'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b1, 16'(k) * 16'h0101, 1'b0, 3'd0);
      chk($sformatf("ovf push%0d level", k), 32'(fifo_level), (k > 8) ? 32'd8 : 32'(k));
      chk($sformatf("ovf push%0d flag", k), 32'(overflow), (k == 9) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
      chk($sformatf("ovf pop%0d sample", k), 32'(codec_sample), 32'(16'(k) * 16'h0101));
      chk($sformatf("ovf pop%0d level", k), 32'(fifo_level), 32'(8 - k));
    end
    chk("ovf sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop: no drop, level stays 8.
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    r[0] = 16'h8000;
    for (int k = 1; k < 8; k++) r[k] = 16'(k) * 16'h1111;
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, r[k], 1'b0, 3'd0);
    chk_all("refill", 16'h0, 1'b0, 4'd8, 1'b0, 8'd0);
    step(1'b0, 1'b1, 16'h5555, 1'b1, 3'd1);
    chk_all("full push+pop", 16'hC000, 1'b1, 4'd8, 1'b0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
      chk($sformatf("drain%0d sample", k), 32'(codec_sample),
          (k == 8) ? 32'h5555 : 32'(r[k]));
    end
    chk("drain level", 32'(fifo_level), 32'd0);
    chk("drain overflow", 32'(overflow), 32'd0);

    // Underrun saturation: each round primes, drains, then underruns once.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 16'h0123, 1'b0, 3'd0);
      step(1'b0, 1'b1, 16'h0456, 1'b0, 3'd0);
      step(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
      step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
      exp_unr = (i + 1 > 255) ? 255 : i + 1;
      chk($sformatf("sat round%0d", i), 32'(underrun_count), 32'(exp_unr));
    end
    chk_all("sat end", 16'h0, 1'b1, 4'd0, 1'b0, 8'd255);

    // Reset mid-stream at level 5 in RUN.
    for (int k = 1; k <= 6; k++) step(1'b0, 1'b1, 16'h0A00 + 16'(k), 1'b0, 3'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk_all("pre-reset", 16'h0A01, 1'b1, 4'd5, 1'b0, 8'd255);
    step(1'b1, 1'b0, 16'h0, 1'b0, 3'd0);
    chk_all("mid reset", 16'h0, 1'b0, 4'd0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk_all("post-reset frame", 16'h0, 1'b1, 4'd0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 16'h0777, 1'b0, 3'd0);
    step(1'b0, 1'b1, 16'h0778, 1'b0, 3'd0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 3'd0);
    chk_all("post-reset pop", 16'h0777, 1'b1, 4'd1, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
